// File: rtl/data_cache_pkg.sv
// Shared types and constants for the direct-mapped write-through data cache.
// Load/store funct3 encodings mirror the MEM-stage memcontrol field.
package data_cache_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  localparam logic [2:0] MC_LB  = 3'b000;
  localparam logic [2:0] MC_LH  = 3'b001;
  localparam logic [2:0] MC_LW  = 3'b010;
  localparam logic [2:0] MC_LBU = 3'b100;
  localparam logic [2:0] MC_LHU = 3'b101;

  localparam logic [2:0] MC_SB  = 3'b000;
  localparam logic [2:0] MC_SH  = 3'b001;
  localparam logic [2:0] MC_SW  = 3'b010;

  localparam logic [31:0] DEADBEEF = 32'hdeadbeef;

  function automatic logic is_load_mc(logic [2:0] mc);
    return mc inside {MC_LB, MC_LH, MC_LW, MC_LBU, MC_LHU};
  endfunction

  function automatic logic is_store_mc(logic [2:0] mc);
    return mc inside {MC_SB, MC_SH, MC_SW};
  endfunction

endpackage

// File: rtl/data_cache_if.sv
// MEM-stage request bus plus the data_mem side port of the cache.
// master = pipeline and memory environment, slave = the cache itself.
interface data_cache_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);

  logic [ADDRESS_WIDTH-1:0] a;
  logic                     re;
  logic                     we;
  logic [DATA_WIDTH-1:0]    writedata;
  logic [2:0]               memcontrol;
  logic [DATA_WIDTH-1:0]    readdata;
  logic                     stall;

  logic [ADDRESS_WIDTH-1:0] mem_a;
  logic                     mem_we;
  logic [DATA_WIDTH-1:0]    mem_writedata;
  logic [2:0]               mem_memcontrol;
  logic [DATA_WIDTH-1:0]    mem_readdata;

  logic [31:0]              hit_count;
  logic [31:0]              miss_count;

  modport master (
    output a, re, we, writedata, memcontrol,
    output mem_readdata,
    input  readdata, stall,
    input  mem_a, mem_we, mem_writedata, mem_memcontrol,
    input  hit_count, miss_count
  );

  modport slave (
    input  a, re, we, writedata, memcontrol,
    input  mem_readdata,
    output readdata, stall,
    output mem_a, mem_we, mem_writedata, mem_memcontrol,
    output hit_count, miss_count
  );

endinterface

// File: rtl/data_cache_load_extend.sv
// Byte/half/word lane select and sign/zero extension of a cached word.
// Unknown memcontrol codes produce the DEADBEEF marker.
module load_extend
  import data_cache_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  mc,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    unique case (mc)
      MC_LB:   data = {{24{b[7]}}, b};
      MC_LH:   data = {{16{h[15]}}, h};
      MC_LW:   data = word;
      MC_LBU:  data = {24'h0, b};
      MC_LHU:  data = {16'h0, h};
      default: data = DEADBEEF;
    endcase
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache, one word/line.
// Load hits answer combinationally; load misses stall for a one-cycle fill.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int BYTE_WIDTH    = 8,
  parameter int SETS          = 8
) (
  input logic       clk,
  input logic       rst,
  data_cache_if.slave bus
);

  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDRESS_WIDTH - 2 - IDX_W;
  localparam int HALF_W = 2 * BYTE_WIDTH;

  typedef logic [IDX_W-1:0]         idx_t;
  typedef logic [TAG_W-1:0]         tag_t;
  typedef logic [DATA_WIDTH-1:0]    word_t;
  typedef logic [ADDRESS_WIDTH-1:0] addr_t;

  state_e      state_q, state_d;
  addr_t       fill_a_q, fill_a_d;
  logic        replay_q, replay_d;
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  logic valid_q [SETS];
  logic valid_d [SETS];
  tag_t tag_q   [SETS];
  tag_t tag_d   [SETS];
  word_t data_q [SETS];
  word_t data_d [SETS];

  idx_t  idx, fill_idx;
  tag_t  tag, fill_tag;
  logic  hit, is_st, is_ld, ld_ok, st_ok;
  logic  ld_hit, ld_miss;
  word_t hit_word, hit_data;

  assign idx      = bus.a[2 +: IDX_W];
  assign tag      = bus.a[2+IDX_W +: TAG_W];
  assign fill_idx = fill_a_q[2 +: IDX_W];
  assign fill_tag = fill_a_q[2+IDX_W +: TAG_W];

  assign hit      = valid_q[idx] && (tag_q[idx] == tag);
  assign hit_word = data_q[idx];

  assign is_st = bus.we;
  assign is_ld = bus.re && !bus.we;
  assign ld_ok = is_load_mc(bus.memcontrol);
  assign st_ok = is_store_mc(bus.memcontrol);

  assign ld_hit  = (state_q == IDLE) && is_ld && ld_ok && hit;
  assign ld_miss = (state_q == IDLE) && is_ld && ld_ok && !hit;

  load_extend u_ext (
    .word (hit_word),
    .off  (bus.a[1:0]),
    .mc   (bus.memcontrol),
    .data (hit_data)
  );

  function automatic word_t merge(
    word_t      old,
    word_t      wd,
    logic [1:0] off,
    logic [2:0] mc
  );
    word_t w;
    w = old;
    unique case (mc)
      MC_SB:   w[int'(off)*BYTE_WIDTH +: BYTE_WIDTH] = wd[BYTE_WIDTH-1:0];
      MC_SH:   w[int'(off[1])*HALF_W +: HALF_W] = wd[HALF_W-1:0];
      MC_SW:   w = wd;
      default: w = old;
    endcase
    return w;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (ld_miss) state_d = FILL;
      FILL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.readdata       = '0;
    bus.stall          = 1'b0;
    bus.mem_a          = bus.a;
    bus.mem_we         = 1'b0;
    bus.mem_writedata  = bus.writedata;
    bus.mem_memcontrol = bus.memcontrol;
    unique case (state_q)
      IDLE: begin
        if (is_st) begin
          bus.mem_we = 1'b1;
        end else if (is_ld) begin
          if (!ld_ok)   bus.readdata = DEADBEEF;
          else if (hit) bus.readdata = hit_data;
          else          bus.stall    = 1'b1;
        end
      end
      FILL: begin
        bus.stall          = 1'b1;
        bus.mem_a          = fill_a_q;
        bus.mem_memcontrol = MC_LW;
      end
      default: ;
    endcase
    // Reset must not leak a stall or a stray store onto the bus.
    if (rst) begin
      bus.stall  = 1'b0;
      bus.mem_we = 1'b0;
    end
  end

  always_comb begin
    valid_d    = valid_q;
    tag_d      = tag_q;
    data_d     = data_q;
    fill_a_d   = fill_a_q;
    replay_d   = (state_q == FILL);
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == FILL) begin
      valid_d[fill_idx] = 1'b1;
      tag_d[fill_idx]   = fill_tag;
      data_d[fill_idx]  = bus.mem_readdata;
    end else if (is_st && st_ok && hit) begin
      data_d[idx] = merge(hit_word, bus.writedata,
                          bus.a[1:0], bus.memcontrol);
    end
    if (ld_miss) begin
      fill_a_d   = {bus.a[ADDRESS_WIDTH-1:2], 2'b00};
      miss_cnt_d = miss_cnt_q + 32'd1;
    end
    // The replayed access after a fill is not a fresh hit.
    if (ld_hit && !replay_q) hit_cnt_d = hit_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SETS; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        data_q[i]  <= '0;
      end
      fill_a_q   <= '0;
      replay_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      for (int i = 0; i < SETS; i++) begin
        valid_q[i] <= valid_d[i];
        tag_q[i]   <= tag_d[i];
        data_q[i]  <= data_d[i];
      end
      fill_a_q   <= fill_a_d;
      replay_q   <= replay_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign bus.hit_count  = hit_cnt_q;
  assign bus.miss_count = miss_cnt_q;

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed scenarios plus random traffic
// checked against a line-address/memory-array reference model.
module tb_data_cache;
  import data_cache_pkg::*;

  logic clk;
  logic rst;
  logic mem_load;

  data_cache_if bus ();

  data_cache #(
    .ADDRESS_WIDTH (32),
    .DATA_WIDTH    (32),
    .BYTE_WIDTH    (8),
    .SETS          (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;

  logic [31:0] seed_mem [64];
  logic [31:0] dmem     [64];
  logic [31:0] ref_mem  [64];
  bit          line_ok   [8];
  int          line_word [8];
  logic [31:0] exp_hit;
  logic [31:0] exp_miss;

  function automatic logic [31:0] store_merge(
    logic [31:0] old, logic [31:0] addr,
    logic [31:0] wd, logic [2:0] mc);
    logic [31:0] mask;
    int sh;
    case (mc)
      3'b000: begin sh = 8 * addr[1:0]; mask = 32'hff << sh; end
      3'b001: begin sh = 16 * addr[1]; mask = 32'hffff << sh; end
      3'b010: begin sh = 0; mask = 32'hffffffff; end
      default: return old;
    endcase
    return (old & ~mask) | ((wd << sh) & mask);
  endfunction

  function automatic logic [31:0] load_ref(
    logic [31:0] w, logic [31:0] addr, logic [2:0] mc);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * addr[1:0])) & 32'hff;
    h = (w >> (16 * addr[1])) & 32'hffff;
    case (mc)
      3'b000:  return (b ^ 32'h80) - 32'h80;
      3'b001:  return (h ^ 32'h8000) - 32'h8000;
      3'b010:  return w;
      3'b100:  return b;
      3'b101:  return h;
      default: return 32'hdeadbeef;
    endcase
  endfunction

  // data_mem: combinational read, store commit on the clock edge
  assign bus.mem_readdata = dmem[bus.mem_a[7:2]];
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 64; i++) dmem[i] <= seed_mem[i];
    end else if (bus.mem_we) begin
      dmem[bus.mem_a[7:2]] <= store_merge(dmem[bus.mem_a[7:2]],
        bus.mem_a, bus.mem_writedata, bus.mem_memcontrol);
    end
  end

  task automatic drive(input logic re_i, input logic we_i,
                       input logic [31:0] a_i, input logic [31:0] wd_i,
                       input logic [2:0] mc_i);
    bus.re = re_i;
    bus.we = we_i;
    bus.a = a_i;
    bus.writedata = wd_i;
    bus.memcontrol = mc_i;
  endtask

  task automatic model_load(input logic [31:0] a_i, input logic [2:0] mc_i,
                            output bit nostall, output logic [31:0] val);
    int wi;
    int ix;
    wi = int'(a_i[7:2]);
    ix = wi % 8;
    val = load_ref(ref_mem[wi], a_i, mc_i);
    if (!(mc_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) begin
      nostall = 1'b1;
    end else begin
      nostall = line_ok[ix] && line_word[ix] == wi;
      if (nostall) exp_hit++;
      else begin
        exp_miss++;
        line_ok[ix] = 1'b1;
        line_word[ix] = wi;
      end
    end
  endtask

  task automatic model_store(input logic [31:0] a_i, input logic [31:0] wd_i,
                             input logic [2:0] mc_i);
    int wi;
    wi = int'(a_i[7:2]);
    ref_mem[wi] = store_merge(ref_mem[wi], a_i, wd_i, mc_i);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      line_ok[i] = 1'b0;
      line_word[i] = -1;
    end
    exp_hit = '0;
    exp_miss = '0;
  endtask

  task automatic do_load(input logic [31:0] a_i, input logic [2:0] mc_i,
                         output int stalls, output logic [31:0] rd,
                         output logic [31:0] fa, output logic [2:0] fmc,
                         output logic fwe);
    drive(1'b1, 1'b0, a_i, 32'h0, mc_i);
    stalls = 0;
    fa = '0;
    fmc = '0;
    fwe = 1'b0;
    @(negedge clk);
    while (bus.stall === 1'b1 && stalls < 8) begin
      if (stalls == 1) begin
        fa = bus.mem_a;
        fmc = bus.mem_memcontrol;
        fwe = bus.mem_we;
      end
      stalls++;
      @(negedge clk);
    end
    rd = bus.readdata;
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
  endtask

  task automatic do_store(input logic [31:0] a_i, input logic [31:0] wd_i,
                          input logic [2:0] mc_i, output logic swe,
                          output logic [31:0] sa, output logic [31:0] swd,
                          output logic [2:0] smc, output logic sst);
    drive(1'b0, 1'b1, a_i, wd_i, mc_i);
    @(negedge clk);
    swe = bus.mem_we;
    sa = bus.mem_a;
    swd = bus.mem_writedata;
    smc = bus.mem_memcontrol;
    sst = bus.stall;
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_load = 1'b1;
    drive(1'b1, 1'b0, 32'h4, 32'h0, MC_LW);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.stall !== 1'b0) begin
      n_err++; $display("FAIL reset_stall got %b want 0", bus.stall);
    end
    n_cmp++;
    if (bus.hit_count !== 32'h0 || bus.miss_count !== 32'h0) begin
      n_err++; $display("FAIL reset_counters got %0d/%0d want 0/0",
                        bus.hit_count, bus.miss_count);
    end
    drive(1'b0, 1'b1, 32'h8, 32'h1234, MC_SW);
    #1;
    n_cmp++;
    if (bus.mem_we !== 1'b0) begin
      n_err++; $display("FAIL reset_mem_we got %b want 0", bus.mem_we);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_load = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    model_clear();
    @(negedge clk);
    n_cmp++;
    if (bus.readdata !== 32'h0 || bus.mem_we !== 1'b0 || bus.stall !== 1'b0) begin
      n_err++; $display("FAIL idle_outputs got rd=%h we=%b st=%b want 0/0/0",
                        bus.readdata, bus.mem_we, bus.stall);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_miss_fill();
    bit nost; logic [31:0] ev, rd, fa; logic [2:0] fmc; logic fwe; int st;
    model_load(32'h4, MC_LW, nost, ev);
    do_load(32'h4, MC_LW, st, rd, fa, fmc, fwe);
    n_cmp++;
    if (st !== 2) begin n_err++; $display("FAIL miss_stall got %0d want 2", st); end
    n_cmp++;
    if (fa !== 32'h4 || fmc !== MC_LW || fwe !== 1'b0) begin
      n_err++; $display("FAIL fill_bus got a=%h mc=%b we=%b want 4/010/0", fa, fmc, fwe);
    end
    n_cmp++;
    if (rd !== 32'h11223344 || rd !== ev) begin
      n_err++; $display("FAIL miss_data got %h want %h", rd, ev);
    end
    n_cmp++;
    if (bus.miss_count !== exp_miss || bus.hit_count !== exp_hit) begin
      n_err++; $display("FAIL miss_counters got %0d/%0d want %0d/%0d",
                        bus.hit_count, bus.miss_count, exp_hit, exp_miss);
    end
  endtask

  task automatic test_hit();
    bit nost; logic [31:0] ev, rd, fa; logic [2:0] fmc; logic fwe; int st;
    model_load(32'h4, MC_LW, nost, ev);
    do_load(32'h4, MC_LW, st, rd, fa, fmc, fwe);
    n_cmp++;
    if (st !== 0 || rd !== ev) begin
      n_err++; $display("FAIL hit_lw got st=%0d rd=%h want 0/%h", st, rd, ev);
    end
    n_cmp++;
    if (bus.hit_count !== exp_hit) begin
      n_err++; $display("FAIL hit_count got %0d want %0d", bus.hit_count, exp_hit);
    end
  endtask

  task automatic test_extend();
    logic [31:0] ta [6] = '{32'h7, 32'h6, 32'h8, 32'h8, 32'h4, 32'h6};
    logic [2:0]  tm [6] = '{MC_LBU, MC_LHU, MC_LB, MC_LH, MC_LB, MC_LH};
    logic [31:0] tv [6] = '{32'h11, 32'h1122, 32'hffffff80,
                            32'h80, 32'h44, 32'h1122};
    bit nost; logic [31:0] ev, rd, fa; logic [2:0] fmc; logic fwe; int st;
    for (int i = 0; i < 6; i++) begin
      model_load(ta[i], tm[i], nost, ev);
      do_load(ta[i], tm[i], st, rd, fa, fmc, fwe);
      n_cmp++;
      if (rd !== tv[i] || st !== (nost ? 0 : 2)) begin
        n_err++; $display("FAIL extend_%0d got rd=%h st=%0d want %h/%0d",
                          i, rd, st, tv[i], nost ? 0 : 2);
      end
    end
  endtask

  task automatic test_store();
    bit nost; logic [31:0] ev, rd, fa, sa, swd, wv; logic [2:0] fmc, smc;
    logic fwe, swe, sst; int st;
    model_store(32'h5, 32'hab, MC_SB);
    do_store(32'h5, 32'hab, MC_SB, swe, sa, swd, smc, sst);
    n_cmp++;
    if (swe !== 1'b1 || sa !== 32'h5 || smc !== MC_SB || sst !== 1'b0) begin
      n_err++; $display("FAIL sb_bus got we=%b a=%h mc=%b st=%b want 1/5/000/0",
                        swe, sa, smc, sst);
    end
    model_load(32'h4, MC_LW, nost, ev);
    do_load(32'h4, MC_LW, st, rd, fa, fmc, fwe);
    n_cmp++;
    if (rd !== 32'h1122ab44 || st !== 0) begin
      n_err++; $display("FAIL sb_merge got rd=%h st=%0d want 1122ab44/0", rd, st);
    end
    model_store(32'h6, 32'hbeef, MC_SH);
    do_store(32'h6, 32'hbeef, MC_SH, swe, sa, swd, smc, sst);
    model_load(32'h4, MC_LW, nost, ev);
    do_load(32'h4, MC_LW, st, rd, fa, fmc, fwe);
    n_cmp++;
    if (rd !== ev || st !== 0) begin
      n_err++; $display("FAIL sh_merge got rd=%h st=%0d want %h/0", rd, st, ev);
    end
    wv = $urandom;
    model_store(32'hc0, wv, MC_SW);
    do_store(32'hc0, wv, MC_SW, swe, sa, swd, smc, sst);
    n_cmp++;
    if (swd !== wv || swe !== 1'b1) begin
      n_err++; $display("FAIL sw_miss_bus got wd=%h we=%b want %h/1", swd, swe, wv);
    end
    model_load(32'hc0, MC_LW, nost, ev);
    do_load(32'hc0, MC_LW, st, rd, fa, fmc, fwe);
    n_cmp++;
    if (rd !== ev || st !== 2) begin
      n_err++; $display("FAIL sw_through got rd=%h st=%0d want %h/2", rd, st, ev);
    end
  endtask

  task automatic test_conflict();
    logic [31:0] ta [3] = '{32'h4, 32'h24, 32'h4};
    int          ts [3] = '{0, 2, 2};
    bit nost; logic [31:0] ev, rd, fa, m0; logic [2:0] fmc; logic fwe; int st;
    m0 = bus.miss_count;
    for (int i = 0; i < 3; i++) begin
      model_load(ta[i], MC_LW, nost, ev);
      do_load(ta[i], MC_LW, st, rd, fa, fmc, fwe);
      n_cmp++;
      if (st !== ts[i] || rd !== ev) begin
        n_err++; $display("FAIL conflict_%0d got st=%0d rd=%h want %0d/%h",
                          i, st, rd, ts[i], ev);
      end
    end
    n_cmp++;
    if (bus.miss_count - m0 !== 32'd2) begin
      n_err++; $display("FAIL conflict_misses got +%0d want +2", bus.miss_count - m0);
    end
  endtask

  task automatic test_bad_mc();
    logic [2:0] bad [3] = '{3'b011, 3'b110, 3'b111};
    bit nost; logic [31:0] ev, rd, fa; logic [2:0] fmc; logic fwe; int st;
    for (int i = 0; i < 3; i++) begin
      model_load(32'h4, bad[i], nost, ev);
      do_load(32'h4, bad[i], st, rd, fa, fmc, fwe);
      n_cmp++;
      if (rd !== 32'hdeadbeef || st !== 0) begin
        n_err++; $display("FAIL bad_mc_%0d got rd=%h st=%0d want deadbeef/0", i, rd, st);
      end
    end
    n_cmp++;
    if (bus.hit_count !== exp_hit || bus.miss_count !== exp_miss) begin
      n_err++; $display("FAIL bad_mc_counters got %0d/%0d want %0d/%0d",
                        bus.hit_count, bus.miss_count, exp_hit, exp_miss);
    end
  endtask

  task automatic test_random();
    logic [2:0] lmc [5] = '{MC_LB, MC_LH, MC_LW, MC_LBU, MC_LHU};
    bit nost; logic [31:0] ev, rd, fa, sa, swd, a, wd; logic [2:0] fmc, smc, mc;
    logic fwe, swe, sst; int st, op;
    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 9);
      a = $urandom_range(0, 255);
      wd = $urandom;
      if (op <= 4) begin
        mc = lmc[$urandom_range(0, 4)];
        if (mc[1:0] == 2'b01) a[0] = 1'b0;
        if (mc == MC_LW) a[1:0] = 2'b00;
        model_load(a, mc, nost, ev);
        do_load(a, mc, st, rd, fa, fmc, fwe);
        n_cmp++;
        if (rd !== ev || st !== (nost ? 0 : 2)) begin
          n_err++; $display("FAIL rand_load_%0d a=%h mc=%b got rd=%h st=%0d want %h/%0d",
                            i, a, mc, rd, st, ev, nost ? 0 : 2);
        end
      end else if (op <= 7) begin
        mc = 3'($urandom_range(0, 2));
        if (mc == MC_SH) a[0] = 1'b0;
        if (mc == MC_SW) a[1:0] = 2'b00;
        model_store(a, wd, mc);
        do_store(a, wd, mc, swe, sa, swd, smc, sst);
        n_cmp++;
        if (swe !== 1'b1 || sa !== a || swd !== wd || smc !== mc || sst !== 1'b0) begin
          n_err++; $display("FAIL rand_store_%0d got we=%b a=%h wd=%h mc=%b st=%b",
                            i, swe, sa, swd, smc, sst);
        end
      end else if (op == 8) begin
        model_load(a, 3'b111, nost, ev);
        do_load(a, 3'b111, st, rd, fa, fmc, fwe);
        n_cmp++;
        if (rd !== 32'hdeadbeef || st !== 0) begin
          n_err++; $display("FAIL rand_bad_%0d got rd=%h st=%0d", i, rd, st);
        end
      end else begin
        @(negedge clk);
        n_cmp++;
        if (bus.readdata !== 32'h0 || bus.mem_we !== 1'b0 || bus.stall !== 1'b0) begin
          n_err++; $display("FAIL rand_idle_%0d got rd=%h we=%b st=%b",
                            i, bus.readdata, bus.mem_we, bus.stall);
        end
        @(posedge clk);
        #1;
      end
    end
    n_cmp++;
    if (bus.hit_count !== exp_hit || bus.miss_count !== exp_miss) begin
      n_err++; $display("FAIL rand_counters got %0d/%0d want %0d/%0d",
                        bus.hit_count, bus.miss_count, exp_hit, exp_miss);
    end
  endtask

  task automatic test_reset_in_fill();
    bit nost; logic [31:0] ev, rd, fa, a; logic [2:0] fmc; logic fwe; int st;
    a = 32'hfc;
    if (line_ok[7] && line_word[7] == 63) a = 32'hdc;
    drive(1'b1, 1'b0, a, 32'h0, MC_LW);
    @(negedge clk);
    n_cmp++;
    if (bus.stall !== 1'b1) begin
      n_err++; $display("FAIL rif_miss_stall got %b want 1", bus.stall);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.stall !== 1'b1 || bus.mem_a !== a) begin
      n_err++; $display("FAIL rif_fill got st=%b a=%h want 1/%h", bus.stall, bus.mem_a, a);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.stall !== 1'b0 || bus.mem_we !== 1'b0) begin
      n_err++; $display("FAIL rif_stall got st=%b we=%b want 0/0", bus.stall, bus.mem_we);
    end
    n_cmp++;
    if (bus.hit_count !== 32'h0 || bus.miss_count !== 32'h0) begin
      n_err++; $display("FAIL rif_counters got %0d/%0d want 0/0",
                        bus.hit_count, bus.miss_count);
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    model_load(a, MC_LW, nost, ev);
    do_load(a, MC_LW, st, rd, fa, fmc, fwe);
    n_cmp++;
    if (st !== 2 || rd !== ev) begin
      n_err++; $display("FAIL rif_pending got st=%0d rd=%h want 2/%h", st, rd, ev);
    end
    model_load(32'h4, MC_LW, nost, ev);
    do_load(32'h4, MC_LW, st, rd, fa, fmc, fwe);
    n_cmp++;
    if (st !== 2 || rd !== ev) begin
      n_err++; $display("FAIL rif_lw4 got st=%0d rd=%h want 2/%h", st, rd, ev);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 64; i++) seed_mem[i] = $urandom;
    seed_mem[1] = 32'h11223344;
    seed_mem[2] = 32'h00000080;
    for (int i = 0; i < 64; i++) ref_mem[i] = seed_mem[i];
    model_clear();
    test_reset();
    test_miss_fill();
    test_hit();
    test_extend();
    test_store();
    test_conflict();
    test_bad_mc();
    test_random();
    test_reset_in_fill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-through, no-write-allocate data cache that sits between the MEM stage of the pipeline and `data_mem`. It accepts the same load/store requests the pipeline would otherwise send straight to `data_mem`, answers load hits combinationally, and refills lines on load misses with a one-word read from `data_mem` while stalling the pipeline. Stores always pass through to `data_mem`; the cache updates its copy only on a hit. It also keeps load hit and miss counters for performance measurement.

## Interface
- `ADDRESS_WIDTH`, 32, address width.
- `DATA_WIDTH`, 32, data width; line size is one word.
- `BYTE_WIDTH`, 8, byte width.
- `SETS`, 8, number of lines; power of two, at least 2.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `a`  in  ADDRESS_WIDTH  byte address from the ALU result.
- `re`  in  1  load request.
- `we`  in  1  store request; has priority over `re`.
- `writedata`  in  DATA_WIDTH  store data.
- `memcontrol`  in  3  funct3 of the load/store instruction.
- `readdata`  out  DATA_WIDTH  load result, byte/half extended.
- `stall`  out  1  pipeline must hold `a`, `re` and `memcontrol` stable while this is high.
- `mem_a`  out  ADDRESS_WIDTH  address to `data_mem`.
- `mem_we`  out  1  write enable to `data_mem`.
- `mem_writedata`  out  DATA_WIDTH  write data to `data_mem`.
- `mem_memcontrol`  out  3  memcontrol to `data_mem`.
- `mem_readdata`  in  DATA_WIDTH  combinational read data from `data_mem`.
- `hit_count`  out  32  count of load hits.
- `miss_count`  out  32  count of load misses.

## Operation
- Address fields: offset = `a[1:0]`; index = `a[2+log2(SETS)-1:2]`; tag = the remaining upper bits.
- Per-line state: valid bit, tag, one data word.
- FSM states are IDLE and FILL.
- IDLE, store (`we`=1):
  - Drive `mem_we`=1 and pass `a`, `writedata` and `memcontrol` through to the `mem_*` outputs in the same cycle. `stall`=0.
  - On a hit with a valid store memcontrol (000 byte, 001 half, 010 word), merge the written bytes into the cached word at the clock edge. The half store uses `a[1]`; the word store ignores the offset bits.
  - On a miss, the cache is not changed.
- IDLE, load (`re`=1, `we`=0) with a valid load memcontrol (000, 001, 010, 100, 101):
  - On a hit, `readdata` is the cached word extracted per memcontrol (lb/lh sign-extend, lbu/lhu zero-extend, lw whole word), combinationally, with `stall`=0.
  - On a miss, `stall`=1, the word-aligned address is registered, and the FSM moves to FILL.
- IDLE, load with any other memcontrol: `readdata`=32'hdeadbeef, no stall, no fill, counters unchanged.
- FILL:
  - Drive `stall`=1, `mem_we`=0, `mem_a` = registered aligned address, `mem_memcontrol`=010.
  - At the edge, write `mem_readdata`, the tag and valid=1 into the line, then return to IDLE.
  - The replayed access in the next IDLE cycle hits.
- With no request, `mem_we`=0 and `readdata`=0.
- Counters:
  - `miss_count` increments on the IDLE→FILL transition.
  - `hit_count` increments on an IDLE load hit, except the replay cycle that immediately follows FILL, which is flagged by a register.
  - Both counters wrap modulo 2^32.
- `re`=`we`=1 is treated as a store.

## Timing
- Load hit latency: 0 cycles, combinational.
- Load miss: `stall` is high for exactly 2 cycles (the miss cycle in IDLE and the FILL cycle); data is valid in the 3rd cycle.
- Stores never stall; `data_mem` commits the store on the same edge the cache merges it.
- Reset: all valid bits 0, state IDLE, both counters 0, replay flag 0. While `rst`=1, `stall`=0 and `mem_we`=0.
- Reset asserted during FILL: return to IDLE immediately; the pending line is not written.
- No store can occur during FILL, because the pipeline is stalled.

## Structure
- Package `data_cache_pkg`:
  - FSM state enum (IDLE, FILL).
  - memcontrol constants LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=000, SH=001, SW=010.
  - The DEADBEEF constant.
- Sub-module `load_extend`: combinational byte/half/word selection and extension from a 32-bit word, `a[1:0]` and memcontrol. It is instantiated once, on the hit path.
- The tag/valid/data arrays stay in `data_cache` as registers so that reset can clear the valid bits.

## Test plan
1. Reset, then `data_mem[0x4..0x7]` = 0x11223344, then lw 0x4:
   - `stall` high for 2 cycles; in FILL, `mem_a`=0x4 and `mem_memcontrol`=010.
   - Then `readdata`=0x11223344 with `stall`=0; `miss_count`=1, `hit_count`=0.
2. lw 0x4 again → same-cycle `readdata`=0x11223344, `stall`=0, `hit_count`=1.
3. Extension on cached lines:
   - lbu 0x7 → 0x00000011.
   - lhu 0x6 → 0x00001122.
   - Line 0x8 filled with 0x00000080, then lb 0x8 → 0xFFFFFF80.
4. sb 0xAB to 0x5 (hit) → `mem_we`=1 with `mem_a`=0x5 and `mem_memcontrol`=000 in the same cycle; next lw 0x4 hits and returns 0x1122AB44.
5. Conflict (SETS=8):
   - lw 0x4, then lw 0x24 → miss evicts the line.
   - lw 0x4 → misses again; `miss_count` increases by 2.
6. Assert `rst` during FILL:
   - `stall`=0 at once; counters are 0 after reset.
   - lw 0x4 after reset misses (valid bits cleared).
